// File: rtl/riscv_input_conditioner_pkg.sv
// Shared types and constants for the board-input conditioner in front of riscV_top.
package riscv_io_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_RST_HOLD        = 3;
    localparam int DEF_SW_WIDTH        = 2;

    // One counter serves both the debounce and hold phases, so size it for the longer one.
    function automatic int cnt_w(input int debounce_cycles, input int rst_hold);
        int m;
        m = (debounce_cycles > rst_hold) ? debounce_cycles : rst_hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/riscv_input_conditioner_if.sv
// Board-side bundle: raw button/switches in, conditioned core controls out.
interface riscv_input_conditioner_if
    import riscv_io_pkg::*;
#(
    parameter int SW_WIDTH = DEF_SW_WIDTH
);
    logic                btn_raw;
    logic [SW_WIDTH-1:0] sw_raw;
    logic                cpu_rst;
    logic [SW_WIDTH-1:0] prog_sel;
    logic                start_pulse;
    logic                busy;

    modport master (
        output btn_raw, sw_raw,
        input  cpu_rst, prog_sel, start_pulse, busy
    );

    modport slave (
        input  btn_raw, sw_raw,
        output cpu_rst, prog_sel, start_pulse, busy
    );
endinterface

// File: rtl/riscv_input_conditioner_io_sync.sv
// Multi-flop synchroniser for asynchronous board inputs, cleared by the async reset.
module io_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
    end

    assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/riscv_input_conditioner.sv
// Debounced button -> timed core reset + start strobe, with switch capture on a qualified press.
// state    | meaning
// IDLE     | core running, waiting for a press
// DEBOUNCE | button seen high, counting consecutive high cycles
// HOLD     | cpu_rst asserted for RST_HOLD cycles, button ignored
// RELEASE  | core released; wait for button release before re-arming
module riscv_input_conditioner
    import riscv_io_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RST_HOLD        = DEF_RST_HOLD,
    parameter int SW_WIDTH        = DEF_SW_WIDTH
) (
    input  logic                       sysclk,
    input  logic                       rst_n,
    riscv_input_conditioner_if.slave   io
);
    localparam int             CNT_W     = cnt_w(DEBOUNCE_CYCLES, RST_HOLD);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    logic                w_btn_s;
    logic [SW_WIDTH-1:0] w_sw_s;

    state_e              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [SW_WIDTH-1:0] r_prog_sel, w_prog_sel_next;
    logic                r_cpu_rst, r_start, r_busy;

    io_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_btn (
        .clk   (sysclk),
        .rst_n (rst_n),
        .i_d   (io.btn_raw),
        .o_q   (w_btn_s)
    );

    io_sync #(.W(SW_WIDTH), .STAGES(SYNC_STAGES)) u_sync_sw (
        .clk   (sysclk),
        .rst_n (rst_n),
        .i_d   (io.sw_raw),
        .o_q   (w_sw_s)
    );

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_prog_sel_next = r_prog_sel;
        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_next = DEBOUNCE;
                    w_cnt_next   = '0;
                end
            end
            DEBOUNCE: begin
                if (!w_btn_s) begin
                    w_state_next = IDLE;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_next    = HOLD;
                    w_cnt_next      = '0;
                    w_prog_sel_next = w_sw_s;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_next = RELEASE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!w_btn_s) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change cleanly on the same edge as the FSM.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HOLD;
            r_cnt      <= '0;
            r_prog_sel <= '0;
            r_cpu_rst  <= 1'b1;
            r_start    <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_prog_sel <= w_prog_sel_next;
            r_cpu_rst  <= (w_state_next == HOLD);
            r_start    <= (r_state == HOLD) && (w_state_next == RELEASE);
            r_busy     <= (w_state_next != IDLE);
        end
    end

    assign io.cpu_rst     = r_cpu_rst;
    assign io.prog_sel    = r_prog_sel;
    assign io.start_pulse = r_start;
    assign io.busy        = r_busy;
endmodule

// File: tb/tb_riscv_input_conditioner.sv
// Scoreboard bench: stimulus queues expected reset windows, a negedge monitor checks them.
module tb_riscv_input_conditioner;
    import riscv_io_pkg::*;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b1;
    always #5 sysclk = ~sysclk;

    riscv_input_conditioner_if io_if ();

    riscv_input_conditioner dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .io     (io_if.slave)
    );

    typedef struct {
        int         start_cyc;
        int         hold_len;
        logic [1:0] sel;
        int         idle_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   pending = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: measures each cpu_rst window and matches it against the expectation at start_pulse.
    int   run = 0;
    int   last_run = 0;
    logic prev_cpu = 1'b1;
    logic prev_start = 1'b0;
    logic prev_busy = 1'b1;

    always @(negedge sysclk) begin
        if (!rst_n) run = 0;
        else if (io_if.cpu_rst) run++;
        else if (prev_cpu) begin
            last_run = run;
            run = 0;
        end

        if (prev_start) begin
            check("start_width", int'(io_if.start_pulse), 0);
        end else if (io_if.start_pulse) begin
            if (exp_q.size() == 0) begin
                check("start_expected", int'(io_if.start_pulse), 0);
            end else begin
                cur = exp_q.pop_front();
                check("start_cycle", cyc, cur.start_cyc);
                check("hold_len", last_run, cur.hold_len);
                check("prog_sel", int'(io_if.prog_sel), int'(cur.sel));
                check("cpu_rst_at_start", int'(io_if.cpu_rst), 0);
                pending = 1'b1;
            end
        end

        if (pending && prev_busy && !io_if.busy) begin
            check("idle_cycle", cyc, cur.idle_cyc);
            pending = 1'b0;
        end

        prev_cpu   = io_if.cpu_rst;
        prev_start = io_if.start_pulse;
        prev_busy  = io_if.busy;
    end

    // Button raised just after edge e: HOLD from e+7, start at e+10, IDLE at e+len+3.
    task automatic press(input logic [1:0] sel, input int len);
        int e;
        exp_t x;
        @(posedge sysclk); #1;
        e = cyc;
        io_if.sw_raw  = sel;
        io_if.btn_raw = 1'b1;
        x.start_cyc = e + 10;
        x.hold_len  = 3;
        x.sel       = sel;
        x.idle_cyc  = e + len + 3;
        exp_q.push_back(x);
        repeat (len) @(posedge sysclk);
        #1 io_if.btn_raw = 1'b0;
        repeat (8) @(posedge sysclk);
    endtask

    task automatic reset_release();
        int r;
        exp_t x;
        #1 rst_n = 1'b1;
        r = cyc;
        x.start_cyc = r + 3;
        x.hold_len  = 3;
        x.sel       = 2'b00;
        x.idle_cyc  = r + 4;
        exp_q.push_back(x);
    endtask

    initial begin
        io_if.btn_raw = 1'b0;
        io_if.sw_raw  = 2'b00;

        // Power-up
        #1 rst_n = 1'b0;
        repeat (2) @(posedge sysclk);
        reset_release();
        repeat (8) @(posedge sysclk);

        // Clean press
        press(2'b01, 12);

        // Bounce rejection
        @(posedge sysclk); #1;
        io_if.sw_raw  = 2'b10;
        io_if.btn_raw = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 io_if.btn_raw = 1'b0;
        repeat (1) @(posedge sysclk);
        #1;
        check("bounce_busy_in_debounce", int'(io_if.busy), 1);
        io_if.btn_raw = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 io_if.btn_raw = 1'b0;
        repeat (8) @(posedge sysclk);
        #1;
        check("bounce_prog_sel", int'(io_if.prog_sel), 1);
        check("bounce_cpu_rst", int'(io_if.cpu_rst), 0);
        check("bounce_busy_idle", int'(io_if.busy), 0);

        // Held button: one window only
        press(2'b00, 40);

        // Switch motion while running
        press(2'b10, 10);
        io_if.sw_raw = 2'b11;
        repeat (6) @(posedge sysclk);
        #1 check("sw_change_ignored", int'(io_if.prog_sel), 2);
        press(2'b11, 10);

        // Async reset during HOLD
        @(posedge sysclk); #1;
        io_if.sw_raw  = 2'b01;
        io_if.btn_raw = 1'b1;
        repeat (8) @(posedge sysclk);
        @(negedge sysclk); #2;
        check("abort_pre_sel", int'(io_if.prog_sel), 1);
        check("abort_pre_cpu_rst", int'(io_if.cpu_rst), 1);
        rst_n = 1'b0;
        io_if.btn_raw = 1'b0;
        #1;
        check("abort_prog_sel", int'(io_if.prog_sel), 0);
        check("abort_cpu_rst", int'(io_if.cpu_rst), 1);
        check("abort_busy", int'(io_if.busy), 1);
        check("abort_start", int'(io_if.start_pulse), 0);
        repeat (2) @(posedge sysclk);
        reset_release();
        repeat (10) @(posedge sysclk);

        #1;
        check("windows_outstanding", exp_q.size(), 0);
        check("idle_outstanding", int'(pending), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
